munoc_stream_distributor: RTL and testbench

Parametrised one-to-N stream distributor for the MUNOC datapath. It accepts a single valid/ready input stream and spreads the beats over NUM_CHANNEL independent show-ahead FIFOs. The target channel is chosen by a binary round-robin pointer. A mode parameter selects either strict rotation, which stalls on a full target, or skip-full rotation, which sends the beat to the next non-full channel. The block sits between a single-issue producer (e.g. a link-layer splitter) and NUM_CHANNEL parallel consumers.

---
 rtl/munoc_stream_distributor.sv | 153 +++++++++++++++
 tb/tb_munoc_stream_distributor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/munoc_stream_distributor.sv
// One-to-N stream distributor: a single valid/ready input spread over NUM_CHANNEL
// show-ahead FIFOs by a round-robin pointer, in strict or skip-full mode.
module munoc_stream_distributor #(
  parameter int  BW_DATA     = 32,
  parameter int  NUM_CHANNEL = 4,
  parameter int  DEPTH       = 2,
  parameter int  SKIP_FULL   = 0,
  localparam int BW_PTR      = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init,
  input  logic                           clear,
  output logic                           wready,
  input  logic                           wrequest,
  input  logic [BW_DATA-1:0]             wdata,
  output logic [BW_PTR-1:0]              wptr,
  output logic [NUM_CHANNEL-1:0]         rready,
  input  logic [NUM_CHANNEL-1:0]         rrequest,
  output logic [NUM_CHANNEL*BW_DATA-1:0] rdata,
  output logic [NUM_CHANNEL-1:0]         rempty
);

  localparam int BW_CNT = $clog2(DEPTH + 1);
  localparam int BW_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BW_CNT-1:0] CNT_FULL = BW_CNT'(DEPTH);
  localparam logic [BW_IDX-1:0] IDX_LAST = BW_IDX'(DEPTH - 1);
  localparam logic [BW_PTR-1:0] PTR_LAST = BW_PTR'(NUM_CHANNEL - 1);

  logic [BW_PTR-1:0]  ptr_q, ptr_d;
  logic [BW_CNT-1:0]  cnt_q  [NUM_CHANNEL];
  logic [BW_CNT-1:0]  cnt_d  [NUM_CHANNEL];
  logic [BW_IDX-1:0]  head_q [NUM_CHANNEL];
  logic [BW_IDX-1:0]  head_d [NUM_CHANNEL];
  logic [BW_DATA-1:0] mem_q  [NUM_CHANNEL][DEPTH];
  logic [BW_DATA-1:0] mem_d  [NUM_CHANNEL][DEPTH];

  logic [NUM_CHANNEL-1:0] full;
  logic [NUM_CHANNEL-1:0] pop;
  logic [NUM_CHANNEL-1:0] push;
  logic [BW_PTR-1:0]      target;
  logic                   target_ok;
  logic                   accept;

  // Circular successor of a storage slot, valid for any DEPTH.
  function automatic logic [BW_IDX-1:0] next_idx(input logic [BW_IDX-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

  // Slot just past the newest entry: (head + count) mod DEPTH.
  function automatic logic [BW_IDX-1:0] tail_idx(input logic [BW_IDX-1:0] head,
                                                 input logic [BW_CNT-1:0] cnt);
    logic [BW_CNT:0] sum;
    sum = (BW_CNT+1)'(head) + (BW_CNT+1)'(cnt);
    if (sum >= (BW_CNT+1)'(DEPTH)) sum = sum - (BW_CNT+1)'(DEPTH);
    return BW_IDX'(sum);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      full[i]   = (cnt_q[i] == CNT_FULL);
      rready[i] = (cnt_q[i] != '0);
      pop[i]    = rrequest[i] & rready[i];
    end
  end

  // Skip-full search: the lowest free channel at or above ptr wins; otherwise
  // the lowest free channel below ptr, which is the circular order from ptr.
  always_comb begin
    target    = ptr_q;
    target_ok = ~full[ptr_q];
    if (SKIP_FULL != 0) begin
      target_ok = 1'b0;
      for (int c = NUM_CHANNEL - 1; c >= 0; c--) begin
        if (!full[c] && (c < int'(ptr_q))) begin
          target    = BW_PTR'(c);
          target_ok = 1'b1;
        end
      end
      for (int c = NUM_CHANNEL - 1; c >= 0; c--) begin
        if (!full[c] && (c >= int'(ptr_q))) begin
          target    = BW_PTR'(c);
          target_ok = 1'b1;
        end
      end
    end
  end

  assign wready = target_ok & ~clear;
  assign accept = wready & wrequest;

  always_comb begin
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      push[i] = accept & (target == BW_PTR'(i));
    end
  end

  // init wins over the accept-driven advance; the write itself still lands.
  always_comb begin
    ptr_d = ptr_q;
    if (init) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = (target == PTR_LAST) ? '0 : target + 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      cnt_d[i]  = cnt_q[i];
      head_d[i] = head_q[i];
      if (clear) begin
        cnt_d[i]  = '0;
        head_d[i] = '0;
      end else begin
        if (push[i]) mem_d[i][tail_idx(head_q[i], cnt_q[i])] = wdata;
        if (pop[i]) head_d[i] = next_idx(head_q[i]);
        cnt_d[i] = cnt_q[i] + BW_CNT'(push[i]) - BW_CNT'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        cnt_q[i]  <= '0;
        head_q[i] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  // Payload storage is never reset; rdata is masked by rready instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      rdata[BW_DATA*i +: BW_DATA] = rready[i] ? mem_q[i][head_q[i]] : '0;
    end
  end

  assign rempty = ~rready;
  assign wptr   = ptr_q;

endmodule

// File: tb/tb_munoc_stream_distributor.sv
// Bench for munoc_stream_distributor: strict, skip-full and single-channel
// instances share one stimulus stream, scored against a queue-based model.
module tb_munoc_stream_distributor;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic        clear = 1'b0;
  logic        wrequest = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  rrequest = '0;
  logic        fill_probe = 1'b0;

  logic         wready0, wready1, wready2;
  logic [1:0]   wptr0, wptr1;
  logic [0:0]   wptr2;
  logic [3:0]   rready0, rready1, rempty0, rempty1;
  logic [0:0]   rready2, rempty2;
  logic [127:0] rdata0, rdata1;
  logic [31:0]  rdata2;

  munoc_stream_distributor #(.BW_DATA(32), .NUM_CHANNEL(4), .DEPTH(2), .SKIP_FULL(0)) u_strict (
    .clk(clk), .rst(rst), .init(init), .clear(clear), .wready(wready0),
    .wrequest(wrequest), .wdata(wdata), .wptr(wptr0), .rready(rready0),
    .rrequest(rrequest), .rdata(rdata0), .rempty(rempty0));

  munoc_stream_distributor #(.BW_DATA(32), .NUM_CHANNEL(4), .DEPTH(2), .SKIP_FULL(1)) u_skip (
    .clk(clk), .rst(rst), .init(init), .clear(clear), .wready(wready1),
    .wrequest(wrequest), .wdata(wdata), .wptr(wptr1), .rready(rready1),
    .rrequest(rrequest), .rdata(rdata1), .rempty(rempty1));

  munoc_stream_distributor #(.BW_DATA(32), .NUM_CHANNEL(1), .DEPTH(1), .SKIP_FULL(0)) u_single (
    .clk(clk), .rst(rst), .init(init), .clear(clear), .wready(wready2),
    .wrequest(wrequest), .wdata(wdata), .wptr(wptr2), .rready(rready2),
    .rrequest(rrequest[0:0]), .rdata(rdata2), .rempty(rempty2));

  logic         wready_a [NI];
  logic [1:0]   wptr_a   [NI];
  logic [3:0]   rready_a [NI];
  logic [3:0]   rempty_a [NI];
  logic [127:0] rdata_a  [NI];

  assign wready_a[0] = wready0;
  assign wready_a[1] = wready1;
  assign wready_a[2] = wready2;
  assign wptr_a[0]   = wptr0;
  assign wptr_a[1]   = wptr1;
  assign wptr_a[2]   = {1'b0, wptr2};
  assign rready_a[0] = rready0;
  assign rready_a[1] = rready1;
  assign rready_a[2] = {3'b000, rready2};
  assign rempty_a[0] = rempty0;
  assign rempty_a[1] = rempty1;
  assign rempty_a[2] = {3'b111, rempty2};
  assign rdata_a[0]  = rdata0;
  assign rdata_a[1]  = rdata1;
  assign rdata_a[2]  = {96'd0, rdata2};

  always #5 clk = ~clk;

  function automatic int nch(input int m);
    return (m == 2) ? 1 : 4;
  endfunction

  function automatic int depth(input int m);
    return (m == 2) ? 1 : 2;
  endfunction

  function automatic bit skip(input int m);
    return (m == 1);
  endfunction

  // Reference state: pointer, occupancy and expected contents per channel.
  int          ptr_m [NI];
  int          cnt_m [NI][4];
  logic [31:0] exp_q [NI][4][$];
  int          checks = 0;
  int          errors = 0;

  // Channel that receives the next beat, or -1 when nothing can accept it.
  function automatic int pred_target(input int m);
    int c;
    if (!skip(m)) return (cnt_m[m][ptr_m[m]] < depth(m)) ? ptr_m[m] : -1;
    for (int k = 0; k < nch(m); k++) begin
      c = (ptr_m[m] + k) % nch(m);
      if (cnt_m[m][c] < depth(m)) return c;
    end
    return -1;
  endfunction

  function automatic bit pred_wready(input int m);
    return (pred_target(m) >= 0) && !clear;
  endfunction

  task automatic check(input string name, input int m, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  // Model: advances on each clock edge from the stimulus alone.
  initial begin : model
    int t;
    bit acc;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int m = 0; m < NI; m++) begin
          ptr_m[m] = 0;
          for (int c = 0; c < 4; c++) begin
            cnt_m[m][c] = 0;
            exp_q[m][c].delete();
          end
        end
      end else begin
        for (int m = 0; m < NI; m++) begin
          t   = pred_target(m);
          acc = (t >= 0) && !clear && wrequest;
          if (clear) begin
            for (int c = 0; c < 4; c++) begin
              cnt_m[m][c] = 0;
              exp_q[m][c].delete();
            end
          end else begin
            for (int c = 0; c < nch(m); c++) begin
              if (rrequest[c] && cnt_m[m][c] > 0) cnt_m[m][c]--;
            end
            if (acc) begin
              cnt_m[m][t]++;
              exp_q[m][t].push_back(wdata);
            end
          end
          if (init) ptr_m[m] = 0;
          else if (acc) ptr_m[m] = (t + 1) % nch(m);
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle, popping beats as consumers take them.
  initial begin : monitor
    logic [3:0] exp_rdy;
    logic [3:0] exp_emp;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NI; m++) begin
        if (rst) begin
          check("rst_wready", m, 128'(wready_a[m]), 128'(!clear));
          check("rst_wptr", m, 128'(wptr_a[m]), 128'(0));
          check("rst_rready", m, 128'(rready_a[m]), 128'(0));
          check("rst_rempty", m, 128'(rempty_a[m]), 128'(4'hF));
          check("rst_rdata", m, rdata_a[m], 128'(0));
        end else begin
          exp_rdy = '0;
          for (int c = 0; c < nch(m); c++) exp_rdy[c] = (cnt_m[m][c] > 0);
          exp_emp = ~exp_rdy;
          check("wready", m, 128'(wready_a[m]), 128'(pred_wready(m)));
          check("wptr", m, 128'(wptr_a[m]), 128'(ptr_m[m]));
          check("rready", m, 128'(rready_a[m]), 128'(exp_rdy));
          check("rempty", m, 128'(rempty_a[m]), 128'(exp_emp));
          for (int c = 0; c < nch(m); c++) begin
            if (cnt_m[m][c] > 0) begin
              check("rdata", m, 128'(rdata_a[m][32*c +: 32]), 128'(exp_q[m][c][0]));
              if (rrequest[c] && !clear) void'(exp_q[m][c].pop_front());
            end else begin
              check("rdata_idle", m, 128'(rdata_a[m][32*c +: 32]), 128'(0));
            end
          end
        end
      end
      if (fill_probe) begin
        check("fill_wptr", 0, 128'(wptr_a[0]), 128'(0));
        check("fill_wready", 0, 128'(wready_a[0]), 128'(0));
        for (int c = 0; c < 4; c++) begin
          check("fill_head", 0, 128'(rdata_a[0][32*c +: 32]), 128'(32'hA0 + 32'(c)));
        end
      end
    end
  end

  task automatic cyc(input bit wr, input logic [31:0] d, input logic [3:0] rr,
                     input bit in, input bit cl);
    wrequest = wr;
    wdata    = d;
    rrequest = rr;
    init     = in;
    clear    = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fill all four channels back to back, then probe the heads.
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'hA0 + 32'(k), 4'h0, 1'b0, 1'b0);
    fill_probe = 1'b1;
    cyc(1'b0, '0, 4'h0, 1'b0, 1'b0);
    fill_probe = 1'b0;
    repeat (3) cyc(1'b0, '0, 4'hF, 1'b0, 1'b0);

    // Strict stall on channel 1 while the others drain, then release it.
    cyc(1'b0, '0, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cyc(1'b1, $urandom, 4'b1101, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 4'b0010, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, $urandom, 4'b1101, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 4'hF, 1'b0, 1'b0);

    // Skip-full: channels 1,2 full, ptr=1, then push 0x55 and fill up.
    cyc(1'b0, '0, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 4'b1001, 1'b0, 1'b0);
    cyc(1'b1, 32'h11, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 4'h0, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 4'hF, 1'b0, 1'b0);

    // init with a write at ptr=2, then clear with pops on non-empty FIFOs.
    cyc(1'b0, '0, 4'h0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, '0, 4'hF, 1'b0, 1'b1);
    cyc(1'b0, '0, 4'h0, 1'b0, 1'b0);

    // Continuous request with continuous pop: single-entry FIFO alternates.
    cyc(1'b0, '0, 4'h0, 1'b1, 1'b1);
    repeat (8) cyc(1'b1, $urandom, 4'h1, 1'b0, 1'b0);

    // Random traffic with an asynchronous reset dropped in between edges.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        init  = 1'b0;
        clear = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      cyc(($urandom % 4) != 0, $urandom, 4'($urandom),
          ($urandom % 64) == 0, ($urandom % 64) == 0);
    end

    repeat (4) cyc(1'b0, '0, 4'hF, 1'b0, 1'b0);
    cyc(1'b0, '0, 4'h0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
